bus_arb: RTL

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bus_arb.sv
// ============================================================================
// bus_arb : four-requester one-hot bus arbiter with hold timeout and release gap
// Optional round-robin priority when BUS_ARB_ROUND_ROBIN_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_arb #(
    parameter int HOLD_MAX_TICKS = 200,
    parameter int GAP_TICKS      = 2
) (
    input  logic       __clk,
    input  logic       clo_,
    input  logic [3:0] zg,
    output logic [3:0] zw,
    output logic       busy,
    output logic [1:0] gnt_id,
    output logic       arb_alarm,
    output logic [3:0] masked
);

    localparam int HW = $clog2(HOLD_MAX_TICKS + 1);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX_TICKS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      zw_q, zw_d;
    logic            busy_q, busy_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            alarm_q, alarm_d;
    logic [3:0]      masked_q, masked_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [3:0]      mask_set;
    logic [3:0]      elig;
    logic [1:0]      win;
    logic [1:0]      idx;

    assign elig = zg & ~masked_q;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;

    // Search upward from the pointer; the lowest offset that is eligible wins.
    always_comb begin
        win = rr_q;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (elig[idx]) win = idx;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && elig != 4'b0000) rr_d = win + 2'd1;
    end

    always_ff @(posedge __clk or negedge clo_) begin
        if (!clo_) rr_q <= 2'd0;
        else       rr_q <= rr_d;
    end
`else
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = 2'(k);
            if (elig[idx]) win = idx;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        zw_d     = zw_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        alarm_d  = 1'b0;
        mask_set = 4'b0000;
        case (state_q)
            IDLE: begin
                if (elig != 4'b0000) begin
                    zw_d    = 4'b0001 << win;
                    gnt_d   = win;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A release on the timeout cycle wins over the timeout itself.
                if (!zg[gnt_q]) begin
                    zw_d    = 4'b0000;
                    gap_d   = '0;
                    state_d = (GAP_TICKS == 0) ? IDLE : GAP;
                end else if (hold_q == HOLD_LAST) begin
                    zw_d            = 4'b0000;
                    alarm_d         = 1'b1;
                    mask_set[gnt_q] = 1'b1;
                    gap_d           = '0;
                    state_d         = (GAP_TICKS == 0) ? IDLE : GAP;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: begin
                zw_d    = 4'b0000;
                state_d = IDLE;
            end
        endcase
        masked_d = (masked_q & zg) | mask_set;
        busy_d   = |zw_d;
    end

    always_ff @(posedge __clk or negedge clo_) begin
        if (!clo_) begin
            state_q  <= IDLE;
            zw_q     <= 4'b0000;
            busy_q   <= 1'b0;
            gnt_q    <= 2'd0;
            alarm_q  <= 1'b0;
            masked_q <= 4'b0000;
            hold_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            zw_q     <= zw_d;
            busy_q   <= busy_d;
            gnt_q    <= gnt_d;
            alarm_q  <= alarm_d;
            masked_q <= masked_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
        end
    end

    assign zw        = zw_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;
    assign arb_alarm = alarm_q;
    assign masked    = masked_q;

endmodule

`default_nettype wire
